res_station_n: RTL

Parametrised reservation station for the Tomasulo back end: DEPTH entries, TAG_W-bit ROB tags, CDB_PORTS broadcast buses. Accepts decoded instructions from dispatch, captures missing operands from any CDB port, and issues the oldest ready entry to its functional unit (ALU word format) over a valid/ready handshake. It replaces the fixed single-CDB, 3-bit-tag station and adds age ordering, multi-port wakeup, alloc-cycle bypass and flush.

---
 rtl/res_station_n_if.sv | 53 +++++
 rtl/res_station_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/res_station_n_if.sv
// Dispatch, common-data-bus and functional-unit channels of the reservation station.
// The master side is the surrounding pipeline; the slave side is the station itself.
interface res_station_n_if #(
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32,
    parameter int CDB_PORTS = 2
) ();
    logic                        alloc_valid;
    logic                        alloc_ready;
    logic [3:0]                  alloc_op;
    logic [2:0]                  alloc_funct3;
    logic                        alloc_funct7;
    logic [TAG_W-1:0]            alloc_src1_tag;
    logic [TAG_W-1:0]            alloc_src2_tag;
    logic [DATA_W-1:0]           alloc_src1_data;
    logic [DATA_W-1:0]           alloc_src2_data;
    logic                        alloc_src1_valid;
    logic                        alloc_src2_valid;
    logic [TAG_W-1:0]            alloc_rd_tag;
    logic [DATA_W-1:0]           alloc_pc;

    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_data;

    logic                        issue_valid;
    logic                        issue_ready;
    logic [3:0]                  issue_op;
    logic [2:0]                  issue_funct3;
    logic                        issue_funct7;
    logic [DATA_W-1:0]           issue_src1_data;
    logic [DATA_W-1:0]           issue_src2_data;
    logic [DATA_W-1:0]           issue_pc;
    logic [TAG_W-1:0]            issue_tag;

    modport master (
        output alloc_valid, alloc_op, alloc_funct3, alloc_funct7,
               alloc_src1_tag, alloc_src2_tag, alloc_src1_data, alloc_src2_data,
               alloc_src1_valid, alloc_src2_valid, alloc_rd_tag, alloc_pc,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1_data, issue_src2_data, issue_pc, issue_tag
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_funct3, alloc_funct7,
               alloc_src1_tag, alloc_src2_tag, alloc_src1_data, alloc_src2_data,
               alloc_src1_valid, alloc_src2_valid, alloc_rd_tag, alloc_pc,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1_data, issue_src2_data, issue_pc, issue_tag
    );
endinterface

// File: rtl/res_station_n.sv
// Age-ordered reservation station: multi-port CDB wakeup, alloc-cycle bypass,
// oldest-ready issue and synchronous flush.
module res_station_n #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32,
    parameter int CDB_PORTS = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    res_station_n_if.slave   bus,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              busy_r   [DEPTH];
    logic [3:0]        op_r     [DEPTH];
    logic [2:0]        funct3_r [DEPTH];
    logic              funct7_r [DEPTH];
    logic              s1v_r    [DEPTH];
    logic [TAG_W-1:0]  s1t_r    [DEPTH];
    logic [DATA_W-1:0] s1d_r    [DEPTH];
    logic              s2v_r    [DEPTH];
    logic [TAG_W-1:0]  s2t_r    [DEPTH];
    logic [DATA_W-1:0] s2d_r    [DEPTH];
    logic [TAG_W-1:0]  rd_r     [DEPTH];
    logic [DATA_W-1:0] pc_r     [DEPTH];
    logic [CNT_W-1:0]  rank_r   [DEPTH];
    logic [CNT_W-1:0]  count_r;

    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              sel_found_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [CNT_W-1:0]  sel_rank_s;
    logic              alloc_ready_s;
    logic              alloc_fire_s;
    logic              issue_fire_s;
    logic [DATA_W:0]   byp1_s;
    logic [DATA_W:0]   byp2_s;

    // Returns {hit, data} for a tag; the lowest-numbered matching port wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]            tag,
        input logic [CDB_PORTS-1:0]        vld,
        input logic [CDB_PORTS*TAG_W-1:0]  tags,
        input logic [CDB_PORTS*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, data[p*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Free-slot search, oldest-ready selection and handshake qualification.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        sel_found_s  = 1'b0;
        sel_idx_s    = '0;
        sel_rank_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_r[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (busy_r[i] && s1v_r[i] && s2v_r[i] &&
                (!sel_found_s || (rank_r[i] < sel_rank_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
                sel_rank_s  = rank_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        alloc_ready_s = (count_r < CNT_W'(DEPTH));
        alloc_fire_s  = bus.alloc_valid && alloc_ready_s && !flush;
        issue_fire_s  = sel_found_s && bus.issue_ready && !flush;
        byp1_s = cdb_lookup(bus.alloc_src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp2_s = cdb_lookup(bus.alloc_src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Issue port fields of the selected entry; all zero when nothing is ready.
    always_comb begin
        bus.alloc_ready     = alloc_ready_s;
        bus.issue_valid     = sel_found_s;
        bus.issue_op        = 4'd0;
        bus.issue_funct3    = 3'd0;
        bus.issue_funct7    = 1'b0;
        bus.issue_src1_data = '0;
        bus.issue_src2_data = '0;
        bus.issue_pc        = '0;
        bus.issue_tag       = '0;
        if (sel_found_s) begin
            bus.issue_op        = op_r[sel_idx_s];
            bus.issue_funct3    = funct3_r[sel_idx_s];
            bus.issue_funct7    = funct7_r[sel_idx_s];
            bus.issue_src1_data = s1d_r[sel_idx_s];
            bus.issue_src2_data = s2d_r[sel_idx_s];
            bus.issue_pc        = pc_r[sel_idx_s];
            bus.issue_tag       = rd_r[sel_idx_s];
        end else begin
            bus.issue_valid = 1'b0;
        end
    end

    // Entry storage: allocation, wakeup, issue retirement and rank compaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i]   <= 1'b0;
                op_r[i]     <= 4'd0;
                funct3_r[i] <= 3'd0;
                funct7_r[i] <= 1'b0;
                s1v_r[i]    <= 1'b0;
                s1t_r[i]    <= '0;
                s1d_r[i]    <= '0;
                s2v_r[i]    <= 1'b0;
                s2t_r[i]    <= '0;
                s2d_r[i]    <= '0;
                rd_r[i]     <= '0;
                pc_r[i]     <= '0;
                rank_r[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire_s && (free_idx_s == IDX_W'(i))) begin
                    busy_r[i]   <= 1'b1;
                    op_r[i]     <= bus.alloc_op;
                    funct3_r[i] <= bus.alloc_funct3;
                    funct7_r[i] <= bus.alloc_funct7;
                    s1t_r[i]    <= bus.alloc_src1_tag;
                    s2t_r[i]    <= bus.alloc_src2_tag;
                    rd_r[i]     <= bus.alloc_rd_tag;
                    pc_r[i]     <= bus.alloc_pc;
                    rank_r[i]   <= count_r - (issue_fire_s ? CNT_W'(1) : CNT_W'(0));
                    if (bus.alloc_src1_valid) begin
                        s1v_r[i] <= 1'b1;
                        s1d_r[i] <= bus.alloc_src1_data;
                    end else begin
                        s1v_r[i] <= byp1_s[DATA_W];
                        s1d_r[i] <= byp1_s[DATA_W-1:0];
                    end
                    if (bus.alloc_src2_valid) begin
                        s2v_r[i] <= 1'b1;
                        s2d_r[i] <= bus.alloc_src2_data;
                    end else begin
                        s2v_r[i] <= byp2_s[DATA_W];
                        s2d_r[i] <= byp2_s[DATA_W-1:0];
                    end
                end else if (busy_r[i]) begin
                    if (issue_fire_s && (sel_idx_s == IDX_W'(i))) begin
                        busy_r[i] <= 1'b0;
                    end else begin
                        if (!s1v_r[i]) begin
                            s1v_r[i] <= cdb_lookup(s1t_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data) >> DATA_W;
                            s1d_r[i] <= cdb_lookup(s1t_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data) >> 0;
                        end
                        if (!s2v_r[i]) begin
                            s2v_r[i] <= cdb_lookup(s2t_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data) >> DATA_W;
                            s2d_r[i] <= cdb_lookup(s2t_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data) >> 0;
                        end
                        if (issue_fire_s && (rank_r[i] > sel_rank_s)) begin
                            rank_r[i] <= rank_r[i] - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Occupancy counter; flush empties the station.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            case ({alloc_fire_s, issue_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
endmodule
